// File: rtl/instr_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: the 65-bit entry layout
// {adel, pc, instr}, its field offsets and the NOP word shown when the queue is empty.
package instr_fetch_queue_pkg;

  localparam int ENTRY_W   = 65;
  localparam int INSTR_LSB = 0;
  localparam int INSTR_MSB = 31;
  localparam int PC_LSB    = 32;
  localparam int PC_MSB    = 63;
  localparam int ADEL_BIT  = 64;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef logic [ENTRY_W-1:0] fq_entry_t;

  function automatic fq_entry_t fq_pack(input logic adel, input logic [31:0] pc,
                                        input logic [31:0] instr);
    fq_entry_t e;
    e                      = '0;
    e[ADEL_BIT]            = adel;
    e[PC_MSB:PC_LSB]       = pc;
    e[INSTR_MSB:INSTR_LSB] = instr;
    return e;
  endfunction

  function automatic logic [31:0] fq_pc(input fq_entry_t e);
    return e[PC_MSB:PC_LSB];
  endfunction

  function automatic logic [31:0] fq_instr(input fq_entry_t e);
    return e[INSTR_MSB:INSTR_LSB];
  endfunction

  function automatic logic fq_adel(input fq_entry_t e);
    return e[ADEL_BIT];
  endfunction

endpackage

// File: rtl/fq_storage.sv
// Entry storage for the fetch queue: DEPTH x 65-bit register array with one
// write port and one asynchronous read port. Contents are never reset.
module fq_storage
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  fq_entry_t                wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output fq_entry_t                rd_data
);

  fq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read is combinational so the head entry is visible in the same cycle.
  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch-to-decode instruction queue with flush and async active-low reset.
// Define FETCH_QUEUE_BYPASS_EN to present an incoming entry to decode in the same cycle when empty.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  input  logic                     in_adel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic                     out_adel,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic      empty;
  logic      full;
  logic      bypass;
  logic      push;
  logic      pop;
  fq_entry_t in_entry;
  fq_entry_t rd_entry;
  fq_entry_t head_entry;

  assign in_entry = fq_pack(in_adel, in_pc, in_instr);

  fq_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (in_entry),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_entry)
  );

  // Handshake and head selection; resetn gates in_ready so it stays low during reset.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    in_ready = resetn && !full && !flush;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass   = resetn && empty && in_valid && !flush;
`else
    bypass   = 1'b0;
`endif
    out_valid  = (!empty && !flush) || bypass;
    head_entry = bypass ? in_entry : rd_entry;
    // A bypassed entry consumed this cycle never touches storage.
    push       = in_valid && in_ready && !(bypass && out_ready);
    pop        = out_valid && out_ready && !bypass;
  end

  always_comb begin
    out_pc    = 32'h0;
    out_instr = NOP_WORD;
    out_adel  = 1'b0;
    if (out_valid) begin
      out_pc    = fq_pc(head_entry);
      out_instr = fq_instr(head_entry);
      out_adel  = fq_adel(head_entry);
    end
  end

  // Pointers are AW bits wide, so DEPTH being a power of two gives free wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_adel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_adel;
  logic [2:0]  count;

  int checks;
  int failures;

  logic [64:0] mq[$];

  logic        last_ov;
  logic        last_ir;
  logic [31:0] last_pc;
  logic [31:0] last_instr;
  logic [2:0]  last_cnt;

  instr_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_adel   (in_adel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_adel  (out_adel),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check against the model, then advance the model at posedge.
  task automatic do_cycle(input logic fl, input logic iv, input logic [31:0] pc,
                          input logic [31:0] ins, input logic ad, input logic ordy);
    int          sz;
    logic        e_byp;
    logic        e_ov;
    logic        e_ir;
    logic [64:0] head;
    @(negedge clk);
    flush     = fl;
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = ins;
    in_adel   = ad;
    out_ready = ordy;
    #1;
    sz    = mq.size();
    e_byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    e_byp = (sz == 0) && iv && !fl;
`endif
    e_ov = ((sz != 0) && !fl) || e_byp;
    e_ir = (sz != DEPTH) && !fl;
    if (e_byp)        head = {ad, pc, ins};
    else if (sz != 0) head = mq[0];
    else              head = '0;
    if (!e_ov) head = '0;
    last_ov    = out_valid;
    last_ir    = in_ready;
    last_pc    = out_pc;
    last_instr = out_instr;
    last_cnt   = count;
    chk("out_valid", 64'(out_valid), 64'(e_ov));
    chk("in_ready", 64'(in_ready), 64'(e_ir));
    chk("count", 64'(count), 64'(sz));
    chk("out_pc", 64'(out_pc), 64'(head[63:32]));
    chk("out_instr", 64'(out_instr), 64'(head[31:0]));
    chk("out_adel", 64'(out_adel), 64'(head[64]));
    $display("cyc fl=%0b iv=%0b pc=%h ordy=%0b | ov=%0b ir=%0b out_pc=%h cnt=%0d",
             fl, iv, pc, ordy, out_valid, in_ready, out_pc, count);
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (e_ov && ordy && !e_byp) void'(mq.pop_front());
      if (iv && e_ir && !(e_byp && ordy)) mq.push_back({ad, pc, ins});
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    resetn    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    in_adel   = 1'b0;
    out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Fill without consuming
    for (int i = 0; i < 4; i++)
      do_cycle(1'b0, 1'b1, 32'hBFC0_0000 + 32'(4 * i), 32'h1000_0000 + 32'(i), i[0], 1'b0);
    do_cycle(1'b0, 1'b1, 32'hBFC0_0010, 32'h1000_0004, 1'b0, 1'b0);
    chk("fill_count", 64'(last_cnt), 64'd4);
    chk("fill_in_ready", 64'(last_ir), 64'd0);
    chk("fill_head_pc", 64'(last_pc), 64'hBFC0_0000);
    do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("fill_head_hold", 64'(last_pc), 64'hBFC0_0000);

    // Drain, then six entries streamed through across the pointer wrap
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      do_cycle(1'b0, 1'b1, 32'h8000_0100 + 32'(4 * i), 32'h2000_0000 + 32'(i), 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("drain_count", 64'(last_cnt), 64'd0);
    chk("drain_nop", 64'(last_instr), 64'd0);
    chk("drain_valid", 64'(last_ov), 64'd0);

    // Concurrent push and pop at count 2
    do_cycle(1'b0, 1'b1, 32'h0000_0A00, 32'h3000_0000, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b1, 32'h0000_0A04, 32'h3000_0001, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b1, 32'h0000_0A08, 32'h3000_0002, 1'b0, 1'b1);
    chk("conc_count_before", 64'(last_cnt), 64'd2);
    do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("conc_count_after", 64'(last_cnt), 64'd2);
    chk("conc_head", 64'(last_pc), 64'h0000_0A04);

    // Flush at count 3 with a push attempt
    do_cycle(1'b0, 1'b1, 32'h0000_0A0C, 32'h3000_0003, 1'b0, 1'b0);
    do_cycle(1'b1, 1'b1, 32'h0000_0B00, 32'h3000_0004, 1'b0, 1'b0);
    chk("flush_in_ready", 64'(last_ir), 64'd0);
    chk("flush_valid", 64'(last_ov), 64'd0);
    do_cycle(1'b0, 1'b1, 32'h0000_0C00, 32'h3000_0005, 1'b1, 1'b0);
    chk("postflush_count", 64'(last_cnt), 64'd0);
    do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("postflush_valid", 64'(last_ov), 64'd1);
    chk("postflush_pc", 64'(last_pc), 64'h0000_0C00);

    // Asynchronous reset mid-run at count 3
    for (int i = 0; i < 3; i++)
      do_cycle(1'b0, 1'b1, 32'h0000_0D00 + 32'(4 * i), 32'h4000_0000, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_pc", 64'(out_pc), 64'd0);
    mq.delete();
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("relrst_in_ready", 64'(in_ready), 64'd1);
    chk("relrst_count", 64'(count), 64'd0);

    // Empty-queue latency (same cycle with bypass, one cycle later without)
    do_cycle(1'b0, 1'b1, 32'h0000_0E00, 32'h2402_0001, 1'b0, 1'b1);
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("lat_valid", 64'(last_ov), 64'd1);
    chk("lat_instr", 64'(last_instr), 64'h2402_0001);
    do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("lat_count", 64'(last_cnt), 64'd0);
`else
    chk("lat_valid", 64'(last_ov), 64'd0);
    do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("lat_valid_next", 64'(last_ov), 64'd1);
    chk("lat_instr", 64'(last_instr), 64'h2402_0001);
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      do_cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), $urandom,
               $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
